// File: rtl/chacha_inv_rounds_if.sv
// chacha_inv_rounds_if: start/data request and ready/valid/data result bus for chacha_inv_rounds
interface chacha_inv_rounds_if;
    logic         start;
    logic [511:0] data_in;
    logic         ready;
    logic         valid;
    logic [511:0] data_out;
    modport master (output start, data_in, input ready, valid, data_out);
    modport slave (input start, data_in, output ready, valid, data_out);
endinterface

// File: rtl/chacha_inv_rounds.sv
// chacha_inv_rounds: undoes ROUNDS ChaCha half-rounds, one inverse half-round per cycle
module chacha_inv_rounds #(
    parameter int ROUNDS = 20
) (
    input logic clk,
    input logic reset_n,
    chacha_inv_rounds_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    state_t       state_q, state_d;
    logic [4:0]   k_q, k_d;
    logic [511:0] st_q, st_d;
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [127:0] iqr(input logic [127:0] x);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = x;
        b = rotr(b, 7) ^ c;  c = c - d; d = rotr(d, 8) ^ a;  a = a - b;
        b = rotr(b, 12) ^ c; c = c - d; d = rotr(d, 16) ^ a; a = a - b;
        return {a, b, c, d};
    endfunction
    // diagonal groups shift rows b/c/d left by 1/2/3 words relative to the columns
    function automatic logic [511:0] half(input logic [511:0] s, input logic diag);
        logic [511:0] r;
        int o;
        r = s;
        o = diag ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            int ib, ic, id;
            ib = 4 + ((i + o) % 4);
            ic = 8 + ((i + 2 * o) % 4);
            id = 12 + ((i + 3 * o) % 4);
            {r[32*i+:32], r[32*ib+:32], r[32*ic+:32], r[32*id+:32]} =
                iqr({s[32*i+:32], s[32*ib+:32], s[32*ic+:32], s[32*id+:32]});
        end
        return r;
    endfunction
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        st_d    = st_q;
        if (state_q == ROUND) begin
            st_d    = half(st_q, ~k_q[0]);
            k_d     = (k_q == 5'(ROUNDS - 1)) ? 5'd0 : k_q + 5'd1;
            state_d = (k_q == 5'(ROUNDS - 1)) ? DONE : ROUND;
        end else if (bus.start) begin
            st_d    = bus.data_in;
            k_d     = 5'd0;
            state_d = ROUND;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= 5'd0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            st_q    <= st_d;
        end
    end
    assign bus.ready    = state_q != ROUND;
    assign bus.valid    = state_q == DONE;
    assign bus.data_out = st_q;
endmodule
